seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the team's BCD-to-7-segment drivers.
- Samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode strobes) and debounces each digit's pattern.
- Decodes each stable pattern back to a 4-bit BCD value and presents complete frames of NDIG digits over a valid/ready handshake.
- Used for display loopback checking and for reading external displays.

---
 rtl/seg7_scan_capture.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Samples a multiplexed active-low 7-segment bus, debounces each
//               digit, decodes it to BCD and presents NDIG-digit frames over
//               valid/ready. Optional macro SEG7_HEX_EN adds A..F decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
  output logic [4*NDIG-1:0]   out_digits,
  output logic [NDIG-1:0]     out_blank,
  output logic [NDIG-1:0]     out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam int         IW           = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] c_STABLE_CYC = 8'(STABLE_CYC);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Returns {err, blank, value[3:0]}
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] d;
    d = 6'b100000;
    case (p)
      7'b1000000: d = 6'h00;
      7'b1111001: d = 6'h01;
      7'b0100100: d = 6'h02;
      7'b0110000: d = 6'h03;
      7'b0011001: d = 6'h04;
      7'b0010010: d = 6'h05;
      7'b0000010: d = 6'h06;
      7'b1111000: d = 6'h07;
      7'b0000000: d = 6'h08;
      7'b0010000: d = 6'h09;
      7'b1111111: d = 6'b010000;
`ifdef SEG7_HEX_EN
      7'b0001000: d = 6'h0A;
      7'b0000011: d = 6'h0B;
      7'b1000110: d = 6'h0C;
      7'b0100001: d = 6'h0D;
      7'b0000110: d = 6'h0E;
      7'b0001110: d = 6'h0F;
`endif
      default:    d = 6'b100000;
    endcase
    return d;
  endfunction

  logic [6:0]        r_seg;
  logic [NDIG-1:0]   r_an;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [6:0]        r_pat;
  logic [6:0]        w_pat_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_commit;
  logic              w_onehot;
  logic [NDIG-1:0]   w_low;
  logic [5:0]        w_dec;
  logic [NDIG-1:0]   r_mask;
  logic [NDIG-1:0]   w_commit_vec;
  logic              w_complete;
  logic [4*NDIG-1:0] r_hval;
  logic [NDIG-1:0]   r_hblank;
  logic [NDIG-1:0]   r_herr;

  // Idle bus (all lines high) on reset so a 1-digit build does not see a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= '1;
      r_an  <= '1;
    end else begin
      r_seg <= seg_n;
      r_an  <= an_n;
    end
  end

  assign w_low    = ~r_an;
  assign w_onehot = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
  assign w_dec    = decode(r_seg);

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (w_low[k]) w_idx = IW'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (!w_onehot) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_IDLE || w_idx != r_idx || r_seg != r_pat) begin
      w_state_nxt = ST_TRACK;
      w_idx_nxt   = w_idx;
      w_pat_nxt   = r_seg;
      w_cnt_nxt   = 8'd1;
      w_commit    = (c_STABLE_CYC == 8'd1);
    end else if (r_cnt < c_STABLE_CYC) begin
      // Counter saturates at STABLE_CYC so the commit fires exactly once
      w_cnt_nxt = r_cnt + 8'd1;
      w_commit  = (r_cnt + 8'd1 == c_STABLE_CYC);
    end
  end

  assign w_commit_vec = w_commit ? (NDIG'(1) << w_idx) : '0;
  assign w_complete   = &r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hval   <= '0;
      r_hblank <= '0;
      r_herr   <= '0;
      r_mask   <= '0;
    end else begin
      for (int k = 0; k < NDIG; k++) begin
        if (w_commit_vec[k]) begin
          r_hval[4*k +: 4] <= w_dec[3:0];
          r_hblank[k]      <= w_dec[4];
          r_herr[k]        <= w_dec[5];
        end
      end
      r_mask <= (w_complete ? '0 : r_mask) | w_commit_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_digits <= '0;
      out_blank  <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_complete) begin
        out_digits <= r_hval;
        out_blank  <= r_hblank;
        out_err    <= r_herr;
        out_valid  <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Directed frame table plus hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

  localparam int NDIG = 4;
  localparam int STAB = 4;

  localparam logic [6:0] c_P0 = 7'b1000000, c_P1 = 7'b1111001, c_P2 = 7'b0100100;
  localparam logic [6:0] c_P3 = 7'b0110000, c_P4 = 7'b0011001, c_P5 = 7'b0010010;
  localparam logic [6:0] c_P6 = 7'b0000010, c_P7 = 7'b1111000, c_P8 = 7'b0000000;
  localparam logic [6:0] c_P9 = 7'b0010000, c_BLK = 7'b1111111, c_BAD = 7'b0000001;
  localparam logic [6:0] c_PA = 7'b0001000;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] out_digits;
  logic [NDIG-1:0]   out_blank;
  logic [NDIG-1:0]   out_err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  typedef struct {
    logic [27:0] pats;   // digit k pattern at [7k+:7]
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t tbl[5];

  seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(STAB)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .out_digits(out_digits), .out_blank(out_blank), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) vcount++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [6:0] p, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an_n  = '1;
    seg_n = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] p);
    for (int d = 0; d < NDIG; d++) drive(d, p[7*d +: 7], STAB);
    idle(0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_digits"}, 32'(out_digits), 32'd0);
    chk({name, "_blank"}, 32'(out_blank), 32'd0);
    chk({name, "_err"}, 32'(out_err), 32'd0);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int v0;
    tbl[0] = '{{c_P4, c_P3, c_P2, c_P1}, 16'h4321, 4'b0000, 4'b0000};
    tbl[1] = '{{c_P8, c_P7, c_P6, c_P5}, 16'h8765, 4'b0000, 4'b0000};
    tbl[2] = '{{c_P0, c_P9, c_P0, c_P9}, 16'h0909, 4'b0000, 4'b0000};
    tbl[3] = '{{c_P7, c_P3, c_BLK, c_BAD}, 16'h7300, 4'b0010, 4'b0001};
`ifdef SEG7_HEX_EN
    tbl[4] = '{{c_P1, c_P1, c_P1, c_PA}, 16'h111A, 4'b0000, 4'b0000};
`else
    tbl[4] = '{{c_P1, c_P1, c_P1, c_PA}, 16'h1110, 4'b0000, 4'b0001};
`endif

    rst = 1'b1; out_ready = 1'b1; an_n = '1; seg_n = '1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    idle(2);

    for (int f = 0; f < 5; f++) begin
      v0 = vcount;
      scan(tbl[f].pats);
      wait_valid($sformatf("frame%0d", f));
      chk($sformatf("frame%0d_digits", f), 32'(out_digits), 32'(tbl[f].digits));
      chk($sformatf("frame%0d_blank", f), 32'(out_blank), 32'(tbl[f].blank));
      chk($sformatf("frame%0d_err", f), 32'(out_err), 32'(tbl[f].err));
      idle(4);
      chk($sformatf("frame%0d_pulses", f), 32'(vcount - v0), 32'd1);
    end
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Digit 2 held only 3 cycles: no frame until a full scan of digit 2
    v0 = vcount;
    drive(0, c_P1, STAB); drive(1, c_P2, STAB); drive(2, c_P3, STAB - 1);
    drive(3, c_P4, STAB); idle(8);
    chk("short_no_frame", 32'(vcount - v0), 32'd0);
    drive(2, c_P3, STAB); idle(0);
    wait_valid("short_done");
    chk("short_done_digits", 32'(out_digits), 32'h4321);
    idle(4);

    // Two strobes low must not commit digits 0/1
    v0 = vcount;
    drive(2, c_P5, STAB); drive(3, c_P6, STAB);
    an_n = 4'b1100; seg_n = c_P8; repeat (10) @(negedge clk);
    idle(6);
    chk("multi_low_no_frame", 32'(vcount - v0), 32'd0);
    drive(0, c_P2, STAB); drive(1, c_P9, STAB); idle(0);
    wait_valid("multi_low_done");
    chk("multi_low_digits", 32'(out_digits), 32'h6592);
    idle(4);

    // Back-pressure across two frames
    out_ready = 1'b0;
    scan(tbl[0].pats);
    wait_valid("bp_first");
    chk("bp_first_digits", 32'(out_digits), 32'h4321);
    drive(0, c_P5, STAB); drive(1, c_P6, STAB);
    chk("bp_hold_digits", 32'(out_digits), 32'h4321);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_overrun", 32'(overrun), 32'd0);
    drive(2, c_P7, STAB); drive(3, c_P8, STAB); idle(3);
    chk("bp_second_digits", 32'(out_digits), 32'h8765);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-frame clears everything, including partial frames
    drive(0, c_P1, STAB); drive(1, c_P1, 2);
    #1 rst = 1'b1;
    #1 chk_reset("async_reset");
    @(negedge clk); rst = 1'b0;
    v0 = vcount;
    drive(2, c_P1, STAB); drive(3, c_P1, STAB); idle(8);
    chk("post_reset_no_frame", 32'(vcount - v0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
